jk_excitation_driver: RTL and testbench

//  Excitation sequencer that drives a WIDTH-bit bank of JK flip-flops toward

---
 rtl/jk_excitation_driver_if.sv | 21 ++
 rtl/jk_excitation_driver.sv | 84 ++++++++
 tb/tb_jk_excitation_driver.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/jk_excitation_driver_if.sv
// jk_excitation_driver_if: bus between the word producer, the excitation driver and the JK flop bank
//   in_valid/in_ready/in_data : target word handshake (producer -> driver)
//   q_fb                      : flop bank q outputs fed back to the driver
//   j/k                       : flop bank excitation inputs (driver -> bank)
//   done/retries/err/clr_err  : transfer status and sticky-error clear
interface jk_excitation_driver_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] q_fb;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             done;
    logic [3:0]       retries;
    logic             err;
    logic             clr_err;
    modport master (output in_valid, in_data, q_fb, clr_err,
                    input  in_ready, j, k, done, retries, err);
    modport slave  (input  in_valid, in_data, q_fb, clr_err,
                    output in_ready, j, k, done, retries, err);
endinterface

// File: rtl/jk_excitation_driver.sv
// jk_excitation_driver: drives a JK flop bank toward target words with read-back check and bounded retry
//   clk   : rising-edge clock shared with the flop bank
//   rst_n : synchronous active-low reset
//   bus   : slave side of jk_excitation_driver_if (handshake, q_fb, j/k, done, retries, err, clr_err)
module jk_excitation_driver #(
    parameter int WIDTH      = 8,
    parameter int USE_TOGGLE = 0,
    parameter int MAX_RETRY  = 2
) (
    input logic                   clk,
    input logic                   rst_n,
    jk_excitation_driver_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CALC, DRIVE, SETTLE, CHECK, ERROR} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] target_q, target_d, j_q, j_d, k_q, k_d;
    logic [3:0]       retries_q, retries_d;
    logic             err_q, err_d;
    logic             match;
    assign match = bus.q_fb == target_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            target_q  <= '0;
            j_q       <= '0;
            k_q       <= '0;
            retries_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            j_q       <= j_d;
            k_q       <= k_d;
            retries_q <= retries_d;
            err_q     <= err_d;
        end
    end
    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        retries_d = retries_q;
        err_d     = err_q;
        j_d       = '0;
        k_d       = '0;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                target_d  = bus.in_data;
                retries_d = '0;
                state_d   = CALC;
            end
            CALC: begin
                // Don't-care resolved as 1 allows toggling: j = q|t, k = ~(q&t)
                j_d     = (USE_TOGGLE != 0) ? (bus.q_fb | target_q)    : (~bus.q_fb & target_q);
                k_d     = (USE_TOGGLE != 0) ? ~(bus.q_fb & target_q)   : (bus.q_fb & ~target_q);
                state_d = DRIVE;
            end
            DRIVE:  state_d = SETTLE;
            SETTLE: state_d = CHECK;
            CHECK: begin
                if (match) begin
                    state_d = IDLE;
                end else if (retries_q < 4'(MAX_RETRY)) begin
                    retries_d = retries_q + 4'd1;
                    state_d   = CALC;
                end else begin
                    err_d   = 1'b1;
                    state_d = ERROR;
                end
            end
            ERROR: if (bus.clr_err) begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    // Ready is masked while reset is held so the producer never sees a handshake mid-reset
    assign bus.in_ready = rst_n && state_q == IDLE;
    assign bus.done     = state_q == CHECK && match;
    assign bus.j        = j_q;
    assign bus.k        = k_q;
    assign bus.retries  = retries_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_jk_excitation_driver.sv
module tb_jk_excitation_driver;
    logic clk = 0;
    logic rst_n = 0;
    always #5 clk = ~clk;

    jk_excitation_driver_if #(.WIDTH(8)) b0 ();
    jk_excitation_driver_if #(.WIDTH(8)) b1 ();

    jk_excitation_driver #(.WIDTH(8), .USE_TOGGLE(0), .MAX_RETRY(2)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    jk_excitation_driver #(.WIDTH(8), .USE_TOGGLE(1), .MAX_RETRY(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    // JK flop bank models with load and stuck-at-hold controls
    logic       ld = 0, st0 = 0;
    logic [7:0] lv = 0, q0 = 0, q1 = 0;
    always @(posedge clk) begin
        q0 <= ld ? lv : st0 ? q0 : ((b0.j & ~q0) | (~b0.k & q0));
        q1 <= ld ? lv : ((b1.j & ~q1) | (~b1.k & q1));
    end
    assign b0.q_fb = q0;
    assign b1.q_fb = q1;

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       tog;
        logic [7:0] qi;
        logic [7:0] tgt;
        logic [7:0] ej;
        logic [7:0] ek;
    } vec_t;

    task automatic xfer(input vec_t v);
        ld = 1; lv = v.qi;
        @(negedge clk);
        ld = 0;
        if (v.tog) begin b1.in_valid = 1; b1.in_data = v.tgt; end
        else       begin b0.in_valid = 1; b0.in_data = v.tgt; end
        @(negedge clk);
        b0.in_valid = 0; b1.in_valid = 0;
        chk("calc_ready", v.tog ? b1.in_ready : b0.in_ready, 0);
        chk("calc_done",  v.tog ? b1.done : b0.done, 0);
        @(negedge clk);
        chk("drive_j", v.tog ? b1.j : b0.j, v.ej);
        chk("drive_k", v.tog ? b1.k : b0.k, v.ek);
        @(negedge clk);
        chk("settle_jk", v.tog ? (b1.j | b1.k) : (b0.j | b0.k), 0);
        chk("settle_done", v.tog ? b1.done : b0.done, 0);
        @(negedge clk);
        chk("check_done", v.tog ? b1.done : b0.done, 1);
        @(negedge clk);
        chk("post_done", v.tog ? b1.done : b0.done, 0);
        chk("post_ready", v.tog ? b1.in_ready : b0.in_ready, 1);
        chk("post_retries", v.tog ? b1.retries : b0.retries, 0);
        chk("post_q", v.tog ? q1 : q0, v.tgt);
    endtask

    vec_t vecs[7];

    initial begin
        int pulses;
        logic saw_done;
        b0.in_valid = 0; b0.in_data = 0; b0.clr_err = 0;
        b1.in_valid = 0; b1.in_data = 0; b1.clr_err = 0;
        vecs[0] = '{0, 8'h00, 8'hA5, 8'hA5, 8'h00};
        vecs[1] = '{1, 8'hF0, 8'h0F, 8'hFF, 8'hFF};
        vecs[2] = '{0, 8'h3C, 8'h3C, 8'h00, 8'h00};
        vecs[3] = '{0, 8'hFF, 8'h00, 8'h00, 8'hFF};
        vecs[4] = '{1, 8'h3C, 8'h3C, 8'h3C, 8'hC3};
        vecs[5] = '{0, 8'h5A, 8'hA5, 8'hA5, 8'h5A};
        vecs[6] = '{1, 8'h00, 8'h81, 8'h81, 8'hFF};

        // Reset
        repeat (2) @(negedge clk);
        chk("rst_ready", {b0.in_ready, b1.in_ready}, 0);
        chk("rst_jk", {b0.j, b0.k, b1.j, b1.k}, 0);
        rst_n = 1;
        @(negedge clk);
        chk("rel_ready", {b0.in_ready, b1.in_ready}, 2'b11);
        chk("rel_done_err", {b0.done, b0.err, b1.done, b1.err}, 0);
        chk("rel_retries", {b0.retries, b1.retries}, 0);

        for (int i = 0; i < 7; i++) xfer(vecs[i]);

        // Stuck bank: three drive pulses then sticky error
        ld = 1; lv = 8'h00;
        @(negedge clk);
        ld = 0; st0 = 1;
        b0.in_valid = 1; b0.in_data = 8'h01;
        pulses = 0; saw_done = 0;
        for (int c = 0; c < 40 && !b0.err; c++) begin
            @(negedge clk);
            b0.in_valid = 0;
            if (b0.j != 0) pulses++;
            if (b0.done) saw_done = 1;
        end
        chk("stuck_err", b0.err, 1);
        chk("stuck_pulses", pulses, 3);
        chk("stuck_retries", b0.retries, 2);
        chk("stuck_no_done", saw_done, 0);
        chk("stuck_ready", b0.in_ready, 0);
        b0.in_valid = 1; b0.in_data = 8'h00;
        repeat (2) @(negedge clk);
        chk("err_hold", {b0.err, b0.in_ready, b0.j}, {1'b1, 1'b0, 8'h00});
        b0.in_valid = 0;
        b0.clr_err = 1;
        @(negedge clk);
        b0.clr_err = 0; st0 = 0;
        chk("clr_err", b0.err, 0);
        chk("clr_ready", b0.in_ready, 1);

        // clr_err outside ERROR has no effect on a normal transfer
        b0.clr_err = 1;
        xfer('{0, 8'h0F, 8'hF0, 8'hF0, 8'h0F});
        b0.clr_err = 0;

        // Reset during DRIVE
        ld = 1; lv = 8'h00;
        @(negedge clk);
        ld = 0;
        b0.in_valid = 1; b0.in_data = 8'hFF;
        @(negedge clk);
        b0.in_valid = 0;
        @(negedge clk);
        chk("t6_drive_j", b0.j, 8'hFF);
        rst_n = 0;
        @(negedge clk);
        chk("t6_jk", {b0.j, b0.k}, 0);
        chk("t6_done", b0.done, 0);
        chk("t6_ready_in_rst", b0.in_ready, 0);
        rst_n = 1;
        saw_done = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (b0.done) saw_done = 1;
        end
        chk("t6_no_done", saw_done, 0);
        chk("t6_idle_ready", b0.in_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
